// File: rtl/satd_pkg.sv
// Shared constants and pixel/column helpers for the SATD block feeder.
// The feeder and its bank storage both import this package.
package satd_pkg;

   localparam int PIX_W = 8;
   localparam int N     = 8;
   localparam int IDX_W = $clog2(N);
   localparam int ROW_W = N * PIX_W;

   typedef logic [ROW_W-1:0]         row_t;
   typedef logic [N-1:0][ROW_W-1:0]  bank_t;

   function automatic logic [PIX_W-1:0] pix(input row_t row, input logic [IDX_W-1:0] j);
      return row[j*PIX_W +: PIX_W];
   endfunction

   // Column k of a block: pixel j of the result is pixel k of stored row j.
   function automatic row_t transpose_col(input bank_t bank, input logic [IDX_W-1:0] k);
      row_t col;
      col = '0;
      for (int j = 0; j < N; j++) begin
         col[j*PIX_W +: PIX_W] = pix(bank[j], k);
      end
      return col;
   endfunction

endpackage

// File: rtl/satd_blk_bank.sv
// One ping-pong bank: N ORG/CUR row pairs, a row write port and a
// combinational row-or-column read port.
module satd_blk_bank
   import satd_pkg::*;
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [ROW_W-1:0] wr_org,
   input  logic [ROW_W-1:0] wr_cur,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic             rd_col,
   output logic [ROW_W-1:0] rd_org,
   output logic [ROW_W-1:0] rd_cur
);

   bank_t org_q, org_d;
   bank_t cur_q, cur_d;

   always_comb begin
      org_d = org_q;
      cur_d = cur_q;
      if (wr_en) begin
         org_d[wr_idx] = wr_org;
         cur_d[wr_idx] = wr_cur;
      end
   end

   // Pixel storage is deliberately not reset; full flags gate its use.
   always_ff @(posedge clk) begin
      org_q <= org_d;
      cur_q <= cur_d;
   end

   assign rd_org = rd_col ? transpose_col(org_q, rd_idx) : org_q[rd_idx];
   assign rd_cur = rd_col ? transpose_col(cur_q, rd_idx) : cur_q[rd_idx];

endmodule

// File: rtl/satd_block_feeder.sv
// Buffers 8x8 ORG/CUR blocks in two ping-pong banks and replays them to
// the SATD datapath as row or transposed-column beats.
module satd_block_feeder
   import satd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ROW_W-1:0] in_org,
   input  logic [ROW_W-1:0] in_cur,
   input  logic             in_last,
   input  logic             in_transpose,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ROW_W-1:0] ORG,
   output logic [ROW_W-1:0] CUR,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic [1:0]       level,
   output logic             err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             wb_q, wb_d;
   logic             rb_q, rb_d;
   logic [1:0]       full_q, full_d;
   logic [1:0]       mode_q, mode_d;
   logic             err_q, err_d;

   logic             acc, drn, wr_end, rd_end;
   logic [ROW_W-1:0] bank_org [2];
   logic [ROW_W-1:0] bank_cur [2];

   assign in_ready  = rst & ~full_q[wb_q];
   assign out_valid = rst & full_q[rb_q];
   assign acc       = in_valid & in_ready;
   assign drn       = out_valid & out_ready;
   assign wr_end    = (wr_cnt_q == LAST_IDX);
   assign rd_end    = (rd_cnt_q == LAST_IDX);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      localparam logic SEL = 1'(b);
      satd_blk_bank u_bank (
         .clk    (clk),
         .wr_en  (acc && (wb_q == SEL)),
         .wr_idx (wr_cnt_q),
         .wr_org (in_org),
         .wr_cur (in_cur),
         .rd_idx (rd_cnt_q),
         .rd_col (mode_q[b]),
         .rd_org (bank_org[b]),
         .rd_cur (bank_cur[b])
      );
   end

   assign ORG      = bank_org[rb_q];
   assign CUR      = bank_cur[rb_q];
   assign out_idx  = rd_cnt_q;
   assign out_last = rd_end & out_valid;
   assign level    = {1'b0, full_q[0]} + {1'b0, full_q[1]};
   assign err      = err_q;

   // Commit sets full[wb] and drain clears full[rb]; both may fire together
   // because a commit needs !full[wb] and a drain needs full[rb].
   always_comb begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      wb_d     = wb_q;
      rb_d     = rb_q;
      full_d   = full_q;
      mode_d   = mode_q;
      err_d    = err_q;

      if (acc) begin
         if (wr_end) begin
            full_d[wb_q] = 1'b1;
            mode_d[wb_q] = in_transpose;
            wb_d         = ~wb_q;
            wr_cnt_d     = '0;
            if (!in_last) err_d = 1'b1;
         end else if (in_last) begin
            err_d    = 1'b1;
            wr_cnt_d = '0;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end

      if (drn) begin
         if (rd_end) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
            rd_cnt_d     = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         wb_q     <= 1'b0;
         rb_q     <= 1'b0;
         full_q   <= '0;
         mode_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         wb_q     <= wb_d;
         rb_q     <= rb_d;
         full_q   <= full_d;
         mode_q   <= mode_d;
         err_q    <= err_d;
      end
   end

endmodule
